ifns_19di_seq_decoder: RTL and testbench

Multi-cycle, handshaked IFNS decoder controller for the 19-bit data-in, 27-wire crosstalk-avoidance link. It latches one 27-bit IFNS codeword and adds the weight of each set wire, BITS_PER_CYCLE wires per clock, into a 20-bit accumulator. It then presents the 19-bit value with a valid/ready handshake. It sits on the receive side in place of the flat combinational decoder where adder area or timing must be traded for latency.

---
 rtl/ifns_19di_seq_decoder.sv | 178 +++++++++++++++++
 tb/tb_ifns_19di_seq_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifns_19di_seq_decoder.sv
// ifns_19di_seq_decoder
// Multi-cycle IFNS decoder for the 19-bit data-in, 27-wire crosstalk-avoidance link.
// One 27-bit codeword is latched, then BITS_PER_CYCLE wires are weighed per clock and
// summed into an accumulator. The result is offered on a valid/ready handshake.
//
// Parameters
//   BITS_PER_CYCLE  wires weighed per RUN cycle; legal values are 1, 3, 9 and 27
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush_i       synchronous abort, highest priority
//   in_valid_i    codeword offered
//   in_ready_o    high only while idle
//   in_code_i     codeword, bit i-1 is wire d_i
//   out_valid_o   result held
//   out_ready_i   consumer accepts result
//   out_value_o   decoded value (sum modulo 2^19)
//   out_ovf_o     sum exceeded 19 bits
//   busy_o        not idle
//
// Build option
//   IFNS_DEC_OVF_EN  defined: 20-bit accumulator, out_ovf_o reports bit 19.
//                    undefined: 19-bit wrapping accumulator, out_ovf_o tied to 0.

module ifns_19di_seq_decoder #(
  parameter int unsigned BITS_PER_CYCLE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [26:0] in_code_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [18:0] out_value_o,
  output logic        out_ovf_o,
  output logic        busy_o
);

  localparam int unsigned N    = 27 / BITS_PER_CYCLE;
  localparam int unsigned CntW = 5;
`ifdef IFNS_DEC_OVF_EN
  localparam int unsigned AccW = 20;
`else
  localparam int unsigned AccW = 19;
`endif

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 3 || BITS_PER_CYCLE == 9 ||
        BITS_PER_CYCLE == 27)) begin : gen_bad_bits_per_cycle
    $error("BITS_PER_CYCLE must be 1, 3, 9 or 27");
  end

  // Wire weights: F(1)..F(26), then F(28) for d27. Entries past 26 are padding so
  // that every 5-bit index hits a defined entry.
  localparam logic [19:0] Weights [32] = '{
    20'd1,      20'd1,      20'd2,      20'd3,      20'd5,      20'd8,
    20'd13,     20'd21,     20'd34,     20'd55,     20'd89,     20'd144,
    20'd233,    20'd377,    20'd610,    20'd987,    20'd1597,   20'd2584,
    20'd4181,   20'd6765,   20'd10946,  20'd17711,  20'd28657,  20'd46368,
    20'd75025,  20'd121393, 20'd317811, 20'd0,      20'd0,      20'd0,
    20'd0,      20'd0
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [26:0]     shift_q, shift_d;
  logic            out_valid_q, out_valid_d;
  logic [18:0]     out_value_q, out_value_d;
  logic            out_ovf_q, out_ovf_d;

  logic [AccW-1:0] chunk_sum;
  logic [AccW-1:0] acc_sum;
  logic            sum_ovf;

  // Weighted sum of the current chunk; the chunk always sits in the low lanes of
  // the shift register, the counter selects which weights apply.
  always_comb begin
    chunk_sum = '0;
    for (int unsigned l = 0; l < BITS_PER_CYCLE; l++) begin
      logic [CntW-1:0] idx;
      idx = CntW'(32'(cnt_q) * BITS_PER_CYCLE + l);
      if (shift_q[l]) begin
        chunk_sum = chunk_sum + Weights[idx][AccW-1:0];
      end
    end
  end

  assign acc_sum = acc_q + chunk_sum;

`ifdef IFNS_DEC_OVF_EN
  assign sum_ovf = acc_sum[19];
`else
  assign sum_ovf = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_ovf_d   = out_ovf_q;

    if (flush_i) begin
      state_d     = StIdle;
      acc_d       = '0;
      cnt_d       = '0;
      shift_d     = '0;
      out_valid_d = 1'b0;
      out_value_d = '0;
      out_ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            shift_d = in_code_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          acc_d   = acc_sum;
          shift_d = shift_q >> BITS_PER_CYCLE;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) begin
            // Counter parks at 0 so the weight index never leaves the table.
            cnt_d       = '0;
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_value_d = acc_sum[18:0];
            out_ovf_d   = sum_ovf;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = out_valid_q;
  assign out_value_o = out_value_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_ifns_19di_seq_decoder.sv
// Bench for ifns_19di_seq_decoder: four instances (BITS_PER_CYCLE 1, 3, 9, 27) run the
// same directed and random scenarios in parallel against a cycle-level reference model.

module tb_ifns_19di_seq_decoder;

  localparam int NINST = 4;
  localparam int NLIT [NINST] = '{27, 9, 3, 1};
`ifdef IFNS_DEC_OVF_EN
  localparam bit OvfAll = 1'b1;
`else
  localparam bit OvfAll = 1'b0;
`endif

  logic              clk;
  logic [NINST-1:0]  rst_n;
  logic [NINST-1:0]  flush;
  logic [NINST-1:0]  in_valid;
  logic [NINST-1:0]  in_ready;
  logic [26:0]       in_code [NINST];
  logic [NINST-1:0]  out_valid;
  logic [NINST-1:0]  out_ready;
  logic [18:0]       out_value [NINST];
  logic [NINST-1:0]  out_ovf;
  logic [NINST-1:0]  busy;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NINST; g++) begin : gen_dut
    localparam int unsigned B = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 9 : 27;
    ifns_19di_seq_decoder #(.BITS_PER_CYCLE(B)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .flush_i    (flush[g]),
      .in_valid_i (in_valid[g]),
      .in_ready_o (in_ready[g]),
      .in_code_i  (in_code[g]),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready[g]),
      .out_value_o(out_value[g]),
      .out_ovf_o  (out_ovf[g]),
      .busy_o     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned ifns_sum(input logic [26:0] c);
    int unsigned f [29];
    int unsigned s;
    f[1] = 1;
    f[2] = 1;
    for (int i = 3; i <= 28; i++) f[i] = f[i-1] + f[i-2];
    s = 0;
    for (int i = 1; i <= 26; i++) if (c[i-1]) s += f[i];
    if (c[26]) s += f[28];
    return s;
  endfunction

  bit [NINST-1:0] m_run, m_valid, m_ovf;
  int             m_rem [NINST];
  bit [18:0]      m_val [NINST];

  always @(posedge clk) begin
    for (int g = 0; g < NINST; g++) begin
      if (!rst_n[g] || flush[g]) begin
        m_run[g]   <= 1'b0;
        m_valid[g] <= 1'b0;
      end else if (!m_run[g] && !m_valid[g]) begin
        if (in_valid[g]) begin
          int unsigned s;
          s = ifns_sum(in_code[g]);
          m_run[g] <= 1'b1;
          m_rem[g] <= NLIT[g];
          m_val[g] <= s[18:0];
          m_ovf[g] <= OvfAll && (s >= 32'd524288);
        end
      end else if (m_run[g]) begin
        m_rem[g] <= m_rem[g] - 1;
        if (m_rem[g] == 1) begin
          m_run[g]   <= 1'b0;
          m_valid[g] <= 1'b1;
        end
      end else if (out_ready[g]) begin
        m_valid[g] <= 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  bit [NINST-1:0] lit_en, lit_ovf;
  int             lit_val [NINST];
  bit [NINST-1:0] trk;
  int             lat [NINST];

  task automatic chk(input bit ok, input string name, input int g, input longint act,
                     input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%0d required=%0d", name, g, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NINST; g++) begin
      if (!rst_n[g]) begin
        chk(out_valid[g] == 1'b0, "rst_out_valid", g, out_valid[g], 0);
        chk(out_value[g] == 19'd0, "rst_out_value", g, out_value[g], 0);
        chk(out_ovf[g] == 1'b0, "rst_out_ovf", g, out_ovf[g], 0);
        chk(busy[g] == 1'b0, "rst_busy", g, busy[g], 0);
        trk[g] = 1'b0;
      end else begin
        chk(out_valid[g] == m_valid[g], "out_valid", g, out_valid[g], m_valid[g]);
        chk(busy[g] == (m_run[g] | m_valid[g]), "busy", g, busy[g], m_run[g] | m_valid[g]);
        chk(in_ready[g] == !(m_run[g] | m_valid[g]), "in_ready", g, in_ready[g],
            !(m_run[g] | m_valid[g]));
        if (m_valid[g]) begin
          chk(out_value[g] == m_val[g], "out_value", g, out_value[g], m_val[g]);
          chk(out_ovf[g] == m_ovf[g], "out_ovf", g, out_ovf[g], m_ovf[g]);
        end
        if (lit_en[g] && out_valid[g]) begin
          chk(out_value[g] == 19'(lit_val[g]), "lit_value", g, out_value[g], lit_val[g]);
          chk(out_ovf[g] == lit_ovf[g], "lit_ovf", g, out_ovf[g], lit_ovf[g]);
        end
        if (trk[g]) begin
          lat[g]++;
          if (out_valid[g]) begin
            chk(lat[g] == NLIT[g], "latency", g, lat[g], NLIT[g]);
            trk[g] = 1'b0;
          end else if (lat[g] > NLIT[g] + 2) begin
            chk(1'b0, "latency_timeout", g, lat[g], NLIT[g]);
            trk[g] = 1'b0;
          end
        end
        if (flush[g]) begin
          trk[g] = 1'b0;
        end else if (in_valid[g] && !m_run[g] && !m_valid[g]) begin
          trk[g] = 1'b1;
          lat[g] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 60 && (m_run[g] || m_valid[g]); i++) cyc();
  endtask

  task automatic wait_done(input int g);
    for (int i = 0; i < 60 && !m_valid[g]; i++) cyc();
  endtask

  task automatic send(input int g, input logic [26:0] code, input bit le, input int lv,
                      input bit lo);
    wait_idle(g);
    lit_en[g]   = le;
    lit_val[g]  = lv;
    lit_ovf[g]  = lo;
    in_valid[g] = 1'b1;
    in_code[g]  = code;
    cyc();
    in_valid[g] = 1'b0;
    in_code[g]  = 27'($urandom);
  endtask

  task automatic release_out(input int g, input int hold, input bit noise);
    for (int i = 0; i < hold; i++) begin
      in_valid[g] = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      in_code[g]  = 27'($urandom);
      cyc();
    end
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b1;
    cyc();
    out_ready[g] = 1'b0;
    lit_en[g]    = 1'b0;
  endtask

  task automatic decode(input int g, input logic [26:0] code, input bit le, input int lv,
                        input bit lo, input int hold);
    send(g, code, le, lv, lo);
    wait_done(g);
    release_out(g, hold, 1'b1);
  endtask

  task automatic run_inst(input int g);
    // Directed values, hand computed from the Fibonacci weights.
    decode(g, 27'h0000000, 1'b1, 0, 1'b0, 0);
    decode(g, 27'h0000003, 1'b1, 2, 1'b0, 0);
    decode(g, 27'h4000000, 1'b1, 317811, 1'b0, 1);
    decode(g, 27'h0000FFF, 1'b1, 376, 1'b0, 0);
    decode(g, 27'h7FFFFFF, 1'b1, 111333, OvfAll, 2);
    // Back-pressure: hold result for 5 cycles with in_valid noise.
    decode(g, 27'h0000003, 1'b1, 2, 1'b0, 5);

    // Flush two edges into RUN, then a clean decode.
    send(g, 27'h4000000, 1'b0, 0, 1'b0);
    cyc();
    flush[g] = 1'b1;
    cyc();
    flush[g] = 1'b0;
    repeat (3) cyc();
    decode(g, 27'h0000003, 1'b1, 2, 1'b0, 0);

    // Reset during RUN.
    send(g, 27'h7FFFFFF, 1'b0, 0, 1'b0);
    rst_n[g] = 1'b0;
    repeat (2) cyc();
    rst_n[g] = 1'b1;
    cyc();
    // Reset while holding a result.
    send(g, 27'h7FFFFFF, 1'b0, 0, 1'b0);
    wait_done(g);
    rst_n[g] = 1'b0;
    repeat (2) cyc();
    rst_n[g] = 1'b1;
    cyc();
    decode(g, 27'h0000FFF, 1'b1, 376, 1'b0, 0);

    // Random codewords with random hold and occasional flush.
    for (int i = 0; i < 14; i++) begin
      logic [26:0] code;
      code = 27'($urandom);
      if ($urandom_range(3, 0) == 0) code = code & 27'($urandom);
      send(g, code, 1'b0, 0, 1'b0);
      if ($urandom_range(5, 0) == 0) begin
        repeat ($urandom_range(2, 0)) cyc();
        flush[g] = 1'b1;
        cyc();
        flush[g] = 1'b0;
      end else begin
        wait_done(g);
        release_out(g, $urandom_range(3, 0), 1'b1);
      end
    end
    wait_idle(g);
  endtask

  initial begin
    rst_n     = '0;
    flush     = '0;
    in_valid  = '0;
    out_ready = '0;
    lit_en    = '0;
    lit_ovf   = '0;
    for (int g = 0; g < NINST; g++) begin
      in_code[g] = '0;
      lit_val[g] = 0;
    end
    repeat (3) cyc();
    rst_n = '1;
    cyc();
    fork
      run_inst(0);
      run_inst(1);
      run_inst(2);
      run_inst(3);
    join
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
